simd_alu: RTL and testbench

- Parametrised, multi-lane successor to the single-lane 8-bit core ALU.
- Executes one operation across LANES independent WIDTH-bit lanes per issue.
- Uses a valid/ready handshake on both input and output.
- Adds sub/div/logic/shift ops, per-lane masking, an iterative divider with a busy state, and NZP compare.
- Sits between the core's register-file read stage and writeback.

---
 rtl/simd_alu.sv | 185 ++++++++++++++++++
 tb/tb_simd_alu.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_alu.sv
// rtl/simd_alu.sv - multi-lane SIMD ALU with iterative restoring divider
//
// Ports:
//   clock, reset (async, active-low)
//   io_in_valid / io_in_ready         : issue handshake (ready only in IDLE)
//   io_operation, io_compare          : opcode, compare-mode override
//   io_lane_mask                      : per-lane write enable
//   io_rs, io_rt                      : packed operands, lane i at [i*WIDTH +: WIDTH]
//   io_out_valid / io_out_ready       : result handshake (valid only in HOLD)
//   io_output                         : packed per-lane result
//   io_illegal                        : last accepted opcode was unsupported
//   io_busy                           : divider iterating
module simd_alu #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   io_in_valid,
    output logic                   io_in_ready,
    input  logic [3:0]             io_operation,
    input  logic                   io_compare,
    input  logic [LANES-1:0]       io_lane_mask,
    input  logic [LANES*WIDTH-1:0] io_rs,
    input  logic [LANES*WIDTH-1:0] io_rt,
    output logic                   io_out_valid,
    input  logic                   io_out_ready,
    output logic [LANES*WIDTH-1:0] io_output,
    output logic                   io_illegal,
    output logic                   io_busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [3:0] OP_DIV = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [LANES*WIDTH-1:0] out_q, out_d;
    logic                   illegal_q, illegal_d;
    logic [LANES-1:0]       mask_q, mask_d;
    logic [LANES*WIDTH-1:0] quo_q, quo_d;
    logic [LANES*WIDTH-1:0] dvs_q, dvs_d;
    logic [LANES*WIDTH-1:0] rem_q, rem_d;
    logic [SHW-1:0]         cnt_q, cnt_d;

    logic [LANES*WIDTH-1:0] alu_word;
    logic [LANES*WIDTH-1:0] quo_step;
    logic [LANES*WIDTH-1:0] rem_step;
    logic [LANES*WIDTH-1:0] in_bits;
    logic [LANES*WIDTH-1:0] div_bits;

    // Single-cycle lane result; DIV is handled by the iterative path.
    function automatic logic [WIDTH-1:0] lane_op(
        input logic [3:0]       op,
        input logic             cmp,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        r = '0;
        if (cmp) begin
            r = {{(WIDTH-3){1'b0}}, (a < b), (a == b), (a > b)};
        end else begin
            case (op)
                4'd0:    r = a + b;
                4'd1:    r = a - b;
                4'd2:    r = a * b;
                4'd4:    r = a & b;
                4'd5:    r = a | b;
                4'd6:    r = a ^ b;
                4'd7:    r = a << b[SHW-1:0];
                4'd8:    r = a >> b[SHW-1:0];
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [WIDTH-1:0] rem;
        logic [WIDTH-1:0] quo;
        logic [WIDTH-1:0] dvs;
        logic [WIDTH:0]   rem_sh;
        logic             qbit;

        assign rem = rem_q[i*WIDTH +: WIDTH];
        assign quo = quo_q[i*WIDTH +: WIDTH];
        assign dvs = dvs_q[i*WIDTH +: WIDTH];

        // Restoring step: bring in the next dividend bit, subtract if it fits.
        // A zero divisor always "fits", giving an all-ones quotient.
        assign rem_sh = {rem, quo[WIDTH-1]};
        assign qbit   = (rem_sh >= {1'b0, dvs});

        assign rem_step[i*WIDTH +: WIDTH] = qbit ? WIDTH'(rem_sh - {1'b0, dvs})
                                                 : rem_sh[WIDTH-1:0];
        assign quo_step[i*WIDTH +: WIDTH] = {quo[WIDTH-2:0], qbit};

        assign alu_word[i*WIDTH +: WIDTH] = lane_op(io_operation, io_compare,
                                                    io_rs[i*WIDTH +: WIDTH],
                                                    io_rt[i*WIDTH +: WIDTH]);

        assign in_bits[i*WIDTH +: WIDTH]  = {WIDTH{io_lane_mask[i]}};
        assign div_bits[i*WIDTH +: WIDTH] = {WIDTH{mask_q[i]}};
    end

    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        illegal_d = illegal_q;
        mask_d    = mask_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (io_in_valid) begin
                    illegal_d = !io_compare && (io_operation > 4'd8);
                    mask_d    = io_lane_mask;
                    if (!io_compare && (io_operation == OP_DIV)) begin
                        state_d = ST_DIV;
                        quo_d   = io_rs;
                        dvs_d   = io_rt;
                        rem_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_HOLD;
                        out_d   = (alu_word & in_bits) | (out_q & ~in_bits);
                    end
                end
            end
            ST_DIV: begin
                quo_d = quo_step;
                rem_d = rem_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_d = ST_HOLD;
                    out_d   = (quo_step & div_bits) | (out_q & ~div_bits);
                end
            end
            ST_HOLD: begin
                if (io_out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            out_q     <= '0;
            illegal_q <= 1'b0;
            mask_q    <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            illegal_q <= illegal_d;
            mask_q    <= mask_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
        end
    end

    assign io_in_ready  = (state_q == ST_IDLE);
    assign io_out_valid = (state_q == ST_HOLD);
    assign io_busy      = (state_q == ST_DIV);
    assign io_output    = out_q;
    assign io_illegal   = illegal_q;

endmodule

// File: tb/tb_simd_alu.sv
// tb/tb_simd_alu.sv - self-checking bench for simd_alu
module tb_simd_alu;

    localparam int W = 8;
    localparam int L = 4;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           io_in_valid = 1'b0;
    logic           io_in_ready;
    logic [3:0]     io_operation = '0;
    logic           io_compare = 1'b0;
    logic [L-1:0]   io_lane_mask = '0;
    logic [L*W-1:0] io_rs = '0;
    logic [L*W-1:0] io_rt = '0;
    logic           io_out_valid;
    logic           io_out_ready = 1'b0;
    logic [L*W-1:0] io_output;
    logic           io_illegal;
    logic           io_busy;

    simd_alu #(.WIDTH(W), .LANES(L)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_operation (io_operation),
        .io_compare   (io_compare),
        .io_lane_mask (io_lane_mask),
        .io_rs        (io_rs),
        .io_rt        (io_rt),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_output    (io_output),
        .io_illegal   (io_illegal),
        .io_busy      (io_busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int model_out [L];
    logic model_ill = 1'b0;

    typedef struct {
        int           op;
        bit           cmp;
        logic [L-1:0] mask;
        logic [L*W-1:0] rs;
        logic [L*W-1:0] rt;
        logic [L*W-1:0] exp;
        logic         ill;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int lane_ref(input int op, input bit cmp, input int a, input int b);
        int m;
        int sh;
        m  = 1 << W;
        sh = b % W;
        if (cmp) return (a < b) ? 4 : ((a == b) ? 2 : 1);
        case (op)
            0: return (a + b) % m;
            1: return (a - b + m) % m;
            2: return (a * b) % m;
            3: return (b == 0) ? m - 1 : a / b;
            4: return a & b;
            5: return a | b;
            6: return a ^ b;
            7: return (a << sh) % m;
            8: return a >> sh;
            default: return 0;
        endcase
    endfunction

    task automatic model_step(input int op, input bit cmp, input logic [L-1:0] mask,
                              input logic [L*W-1:0] rs, input logic [L*W-1:0] rt,
                              output logic [L*W-1:0] exp, output logic exp_ill);
        for (int i = 0; i < L; i++) begin
            if (mask[i]) model_out[i] = lane_ref(op, cmp, int'(rs[i*W +: W]), int'(rt[i*W +: W]));
            exp[i*W +: W] = W'(model_out[i]);
        end
        model_ill = !cmp && (op > 8);
        exp_ill   = model_ill;
    endtask

    task automatic model_reset();
        for (int i = 0; i < L; i++) model_out[i] = 0;
        model_ill = 1'b0;
    endtask

    // Issue one op, hold in_valid with junk while busy/holding, then drain.
    task automatic run_op(input string name, input int op, input bit cmp, input logic [L-1:0] mask,
                          input logic [L*W-1:0] rs, input logic [L*W-1:0] rt,
                          input logic [L*W-1:0] exp, input logic exp_ill);
        int lat;
        bit is_div;
        is_div = !cmp && (op == 3);
        @(negedge clock);
        check({name, " in_ready"}, io_in_ready, 1);
        io_operation = 4'(op);
        io_compare   = cmp;
        io_lane_mask = mask;
        io_rs        = rs;
        io_rt        = rt;
        io_in_valid  = 1'b1;
        @(posedge clock);
        #1;
        io_operation = 4'($urandom);
        io_compare   = 1'($urandom);
        io_lane_mask = L'($urandom);
        io_rs        = (L*W)'($urandom);
        io_rt        = (L*W)'($urandom);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
            if (!io_out_valid) begin
                check({name, " busy"}, io_busy, 1'(is_div));
                check({name, " ready_low"}, io_in_ready, 0);
            end
        end while (!io_out_valid && lat < 200);
        check({name, " latency"}, 64'(lat), is_div ? 64'(W + 1) : 64'd1);
        check({name, " output"}, io_output, exp);
        check({name, " illegal"}, io_illegal, exp_ill);
        check({name, " hold_ready"}, io_in_ready, 0);
        io_in_valid  = 1'b0;
        io_out_ready = 1'b1;
        @(posedge clock);
        #1;
        io_out_ready = 1'b0;
        @(negedge clock);
        check({name, " idle_valid"}, io_out_valid, 0);
        check({name, " idle_ready"}, io_in_ready, 1);
        check({name, " idle_illegal"}, io_illegal, exp_ill);
    endtask

    initial begin
        logic [L*W-1:0] exp;
        logic           eill;
        logic [L-1:0]   m;
        logic [L*W-1:0] a;
        logic [L*W-1:0] b;
        int             op;
        bit             cmp;

        model_reset();

        // Reset state
        #12;
        check("rst out_valid", io_out_valid, 0);
        check("rst output", io_output, 0);
        check("rst illegal", io_illegal, 0);
        check("rst busy", io_busy, 0);
        check("rst in_ready", io_in_ready, 1);
        @(negedge clock);
        reset = 1'b1;

        tbl.push_back('{0, 1'b1, 4'hF, 32'hFF05030A, 32'h02050A03, 32'h01020401, 1'b0});
        tbl.push_back('{0, 1'b0, 4'hF, 32'hFF05030A, 32'h02050A03, 32'h010A0D0D, 1'b0});
        tbl.push_back('{2, 1'b0, 4'hF, 32'hFF05030A, 32'h02050A03, 32'hFE191E1E, 1'b0});
        tbl.push_back('{3, 1'b0, 4'hF, 32'h07C8030A, 32'h00070A03, 32'hFF1C0003, 1'b0});
        tbl.push_back('{0, 1'b0, 4'hF, 32'h04040404, 32'h05050505, 32'h09090909, 1'b0});
        tbl.push_back('{1, 1'b0, 4'h5, 32'h03030303, 32'h05050505, 32'h09FE09FE, 1'b0});
        tbl.push_back('{12, 1'b0, 4'hF, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1});
        tbl.push_back('{6, 1'b0, 4'hF, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0});
        tbl.push_back('{9, 1'b0, 4'h3, 32'h11111111, 32'h22222222, 32'hFFFF0000, 1'b1});
        tbl.push_back('{15, 1'b1, 4'hF, 32'h00000000, 32'h00000000, 32'h02020202, 1'b0});
        tbl.push_back('{3, 1'b0, 4'hA, 32'h40404040, 32'h08080808, 32'h08020802, 1'b0});
        tbl.push_back('{7, 1'b0, 4'hF, 32'h81010F01, 32'h07000409, 32'h8001F002, 1'b0});
        tbl.push_back('{8, 1'b0, 4'hF, 32'h80FFF081, 32'h07080401, 32'h01FF0F40, 1'b0});
        tbl.push_back('{4, 1'b0, 4'hF, 32'hFF00F0AA, 32'h0F0F3C55, 32'h0F003000, 1'b0});
        tbl.push_back('{5, 1'b0, 4'hF, 32'hFF00F0AA, 32'h0F0F3C55, 32'hFF0FFCFF, 1'b0});

        foreach (tbl[i]) begin
            model_step(tbl[i].op, tbl[i].cmp, tbl[i].mask, tbl[i].rs, tbl[i].rt, exp, eill);
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].cmp, tbl[i].mask,
                   tbl[i].rs, tbl[i].rt, tbl[i].exp, tbl[i].ill);
        end

        // Backpressure: result must sit still while the consumer stalls
        model_step(0, 1'b0, 4'hF, 32'h11111111, 32'h22222222, exp, eill);
        @(negedge clock);
        io_operation = 4'd0; io_compare = 1'b0; io_lane_mask = 4'hF;
        io_rs = 32'h11111111; io_rt = 32'h22222222; io_in_valid = 1'b1;
        @(posedge clock);
        #1;
        io_operation = 4'd3; io_rs = 32'hDEADBEEF; io_rt = 32'h01020304;
        @(negedge clock);
        check("bp first_valid", io_out_valid, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check($sformatf("bp output%0d", k), io_output, exp);
            check($sformatf("bp valid%0d", k), io_out_valid, 1);
            check($sformatf("bp ready%0d", k), io_in_ready, 0);
            check($sformatf("bp busy%0d", k), io_busy, 0);
        end
        io_in_valid = 1'b0;
        io_out_ready = 1'b1;
        @(posedge clock);
        #1;
        io_out_ready = 1'b0;
        @(negedge clock);
        check("bp release_ready", io_in_ready, 1);
        check("bp release_valid", io_out_valid, 0);
        check("bp release_output", io_output, exp);

        // Randomised ops against the reference model
        for (int n = 0; n < 40; n++) begin
            op  = int'($urandom_range(0, 15));
            cmp = ($urandom_range(0, 3) == 0);
            m   = L'($urandom);
            a   = (L*W)'($urandom);
            b   = (L*W)'($urandom);
            if ($urandom_range(0, 3) == 0) b[W-1:0] = '0;
            if ($urandom_range(0, 4) == 0) b = a;
            model_step(op, cmp, m, a, b, exp, eill);
            run_op($sformatf("rnd%0d", n), op, cmp, m, a, b, exp, eill);
        end

        // Reset in the third DIV cycle aborts the divide
        @(negedge clock);
        io_operation = 4'd3; io_compare = 1'b0; io_lane_mask = 4'hF;
        io_rs = 32'hC8C8C8C8; io_rt = 32'h07070707; io_in_valid = 1'b1;
        @(posedge clock);
        #1;
        io_in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("abort busy_before", io_busy, 1);
        reset = 1'b0;
        #1;
        check("abort busy", io_busy, 0);
        check("abort valid", io_out_valid, 0);
        check("abort output", io_output, 0);
        check("abort illegal", io_illegal, 0);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        @(negedge clock);
        check("abort ready", io_in_ready, 1);
        check("abort no_result", io_out_valid, 0);
        model_step(0, 1'b0, 4'hF, 32'h01020304, 32'h10203040, exp, eill);
        run_op("post_abort_add", 0, 1'b0, 4'hF, 32'h01020304, 32'h10203040, exp, eill);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
